// File: rtl/mult_batch_pkg.sv
// mult_batch_pkg: state codes and operand-load select constants for mult_batch_ctrl.
package mult_batch_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_MULT   = 3'd3,
      S_WRITE  = 3'd4,
      S_READ   = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   // {DA, SA, SB} during the two operand-load phases
   localparam logic [2:0] SEL_A = 3'b001;
   localparam logic [2:0] SEL_B = 3'b101;

endpackage

// File: rtl/mult_batch_ctrl_timer.sv
// mult_lat_timer: loadable down-counter that holds at zero; paces the MULT state.
module mult_lat_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (load_i) cnt_q <= val_i;
      else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);

   assign zero_o = cnt_q == '0;

endmodule

// File: rtl/mult_batch_ctrl.sv
// mult_batch_ctrl: batch sequencer that loads operands, waits out the multiplier,
// then writes and reads back each product at auto-incrementing addresses.
module mult_batch_ctrl
   import mult_batch_pkg::*;
#(
   parameter int ADDR_W  = 3,
   parameter int MUL_LAT = 1,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] adr1,
   input  logic [ADDR_W-1:0] adr2,
   input  logic [ADDR_W-1:0] dst_adr,
   input  logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              w_rf,
   output logic [ADDR_W-1:0] rf_adr,
   output logic              DA,
   output logic              SA,
   output logic              SB,
   output logic              w_ram_en,
   output logic              r_ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CNT_W-1:0]  job_idx,
   output logic [2:0]        st_out
);

   localparam int TW = $clog2(MUL_LAT + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] adr1_q, adr1_d, adr2_q, adr2_d, dst_q, dst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, job_q, job_d;
   logic [ADDR_W-1:0] job_a;
   logic              tmr_zero;

   assign job_a = ADDR_W'(job_q);

   // loaded on the LOAD_B->MULT edge so MULT lasts exactly MUL_LAT cycles
   mult_lat_timer #(.W(TW)) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (state_q == S_LOAD_B),
      .val_i  (TW'(MUL_LAT - 1)),
      .zero_o (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         adr1_q  <= '0;
         adr2_q  <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         job_q   <= '0;
      end else begin
         state_q <= state_d;
         adr1_q  <= adr1_d;
         adr2_q  <= adr2_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         job_q   <= job_d;
      end

   always_comb begin
      state_d = state_q;
      adr1_d  = adr1_q;
      adr2_d  = adr2_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      job_d   = job_q;
      case (state_q)
         S_IDLE:
            if (start) begin
               state_d = S_LOAD_A;
               adr1_d  = adr1;
               adr2_d  = adr2;
               dst_d   = dst_adr;
               cnt_d   = count == '0 ? CNT_W'(1) : count;
               job_d   = '0;
            end
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_MULT;
         S_MULT:   state_d = tmr_zero ? S_WRITE : S_MULT;
         S_WRITE:  state_d = S_READ;
         S_READ:
            if (job_q == cnt_q - CNT_W'(1)) state_d = S_DONE;
            else begin
               state_d = S_LOAD_A;
               job_d   = job_q + CNT_W'(1);
            end
         default:  state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         adr1_d  = '0;
         adr2_d  = '0;
         dst_d   = '0;
         cnt_d   = '0;
         job_d   = '0;
      end
   end

   assign busy         = state_q != S_IDLE;
   assign done         = state_q == S_DONE;
   assign w_rf         = state_q == S_LOAD_A || state_q == S_LOAD_B;
   assign {DA, SA, SB} = state_q == S_LOAD_A ? SEL_A : state_q == S_LOAD_B ? SEL_B : 3'b000;
   assign rf_adr       = state_q == S_LOAD_A ? adr1_q + job_a : state_q == S_LOAD_B ? adr2_q + job_a : '0;
   assign w_ram_en     = state_q == S_WRITE;
   assign r_ram_en     = state_q == S_READ;
   assign ram_addr     = (state_q == S_WRITE || state_q == S_READ) ? dst_q + job_a : '0;
   assign job_idx      = state_q == S_IDLE ? '0 : job_q;
   assign st_out       = state_q;

endmodule

// File: tb/tb_mult_batch_ctrl.sv
// tb_mult_batch_ctrl: scoreboard bench; expected strobe events are queued at start
// and popped as the selected DUT (MUL_LAT=1 or MUL_LAT=4) emits them.
module tb_mult_batch_ctrl;

   logic       clk = 0, rst_n = 0, start = 0, abort = 0, sel = 0;
   logic [2:0] adr1 = 0, adr2 = 0, dst_adr = 0;
   logic [3:0] count = 0;

   logic       busy_1, done_1, w_rf_1, DA_1, SA_1, SB_1, w_ram_1, r_ram_1;
   logic [2:0] rf_adr_1, ram_addr_1, st_1;
   logic [3:0] job_1;
   logic       busy_4, done_4, w_rf_4, DA_4, SA_4, SB_4, w_ram_4, r_ram_4;
   logic [2:0] rf_adr_4, ram_addr_4, st_4;
   logic [3:0] job_4;

   logic       m_busy, m_done, m_w_rf, m_DA, m_SA, m_SB, m_w_ram, m_r_ram;
   logic [2:0] m_rf_adr, m_ram_addr, m_st;
   logic [3:0] m_job;
   logic [20:0] outs_1, outs_4;

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] sb[$];
   int          st_hist[0:255];

   always #5 clk = ~clk;

   mult_batch_ctrl #(.ADDR_W(3), .MUL_LAT(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start && !sel), .abort(abort),
      .adr1(adr1), .adr2(adr2), .dst_adr(dst_adr), .count(count),
      .busy(busy_1), .done(done_1), .w_rf(w_rf_1), .rf_adr(rf_adr_1),
      .DA(DA_1), .SA(SA_1), .SB(SB_1), .w_ram_en(w_ram_1), .r_ram_en(r_ram_1),
      .ram_addr(ram_addr_1), .job_idx(job_1), .st_out(st_1)
   );

   mult_batch_ctrl #(.ADDR_W(3), .MUL_LAT(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start && sel), .abort(abort),
      .adr1(adr1), .adr2(adr2), .dst_adr(dst_adr), .count(count),
      .busy(busy_4), .done(done_4), .w_rf(w_rf_4), .rf_adr(rf_adr_4),
      .DA(DA_4), .SA(SA_4), .SB(SB_4), .w_ram_en(w_ram_4), .r_ram_en(r_ram_4),
      .ram_addr(ram_addr_4), .job_idx(job_4), .st_out(st_4)
   );

   assign {m_busy, m_done, m_w_rf, m_DA, m_SA, m_SB, m_w_ram, m_r_ram} = sel ?
      {busy_4, done_4, w_rf_4, DA_4, SA_4, SB_4, w_ram_4, r_ram_4} :
      {busy_1, done_1, w_rf_1, DA_1, SA_1, SB_1, w_ram_1, r_ram_1};
   assign {m_rf_adr, m_ram_addr, m_st, m_job} = sel ?
      {rf_adr_4, ram_addr_4, st_4, job_4} : {rf_adr_1, ram_addr_1, st_1, job_1};
   assign outs_1 = {busy_1, done_1, w_rf_1, rf_adr_1, DA_1, SA_1, SB_1, w_ram_1, r_ram_1, ram_addr_1, job_1, st_1};
   assign outs_4 = {busy_4, done_4, w_rf_4, rf_adr_4, DA_4, SA_4, SB_4, w_ram_4, r_ram_4, ram_addr_4, job_4, st_4};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // kind: 1 rf load, 2 ram write, 3 ram read, 4 done
   function automatic logic [31:0] ev(input logic [2:0] k, input logic [2:0] s,
                                      input logic [2:0] a, input logic [3:0] j);
      return {19'd0, k, s, a, j};
   endfunction

   always @(negedge clk) begin
      logic [31:0] e;
      bit hit;
      hit = 1;
      e = '0;
      if (m_w_rf) e = ev(3'd1, {m_DA, m_SA, m_SB}, m_rf_adr, m_job);
      else if (m_w_ram) e = ev(3'd2, 3'b000, m_ram_addr, m_job);
      else if (m_r_ram) e = ev(3'd3, 3'b000, m_ram_addr, m_job);
      else if (m_done) e = ev(3'd4, 3'b000, 3'b000, m_job);
      else hit = 0;
      if (hit) begin
         if (sb.size() == 0) chk("unexpected_event", e, 32'd0);
         else chk("event", e, sb.pop_front());
      end
   end

   task automatic go(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] d,
                     input logic [3:0] c, input logic s);
      int n;
      @(negedge clk);
      sel = s; abort = 0;
      adr1 = a1; adr2 = a2; dst_adr = d; count = c; start = 1;
      n = c == 0 ? 1 : int'(c);
      for (int j = 0; j < n; j++) begin
         sb.push_back(ev(3'd1, 3'b001, a1 + 3'(j), 4'(j)));
         sb.push_back(ev(3'd1, 3'b101, a2 + 3'(j), 4'(j)));
         sb.push_back(ev(3'd2, 3'b000, d + 3'(j), 4'(j)));
         sb.push_back(ev(3'd3, 3'b000, d + 3'(j), 4'(j)));
      end
      sb.push_back(ev(3'd4, 3'b000, 3'b000, 4'(n - 1)));
      @(negedge clk);
      start = 0;
   endtask

   // steps from cycle 1 until busy drops; n ends as the first idle cycle
   task automatic run(input int poke, input int ab_job, output int n, output int dones,
                      output int mults, output int done_cyc, output int ab_cyc);
      n = 0; dones = 0; mults = 0; done_cyc = 0; ab_cyc = 0;
      for (int i = 0; i < 200; i++) begin
         n++;
         st_hist[n] = int'(m_st);
         if (m_st == 3'd3) mults++;
         if (m_done) begin dones++; done_cyc = n; end
         start = 0; abort = 0;
         if (n == poke) begin
            start = 1; adr1 = ~adr1; adr2 = ~adr2; dst_adr = ~dst_adr; count = 4'd9;
         end
         if (ab_cyc == 0 && m_st == 3'd3 && int'(m_job) == ab_job) begin
            abort = 1; ab_cyc = n;
         end
         if (!m_busy) break;
         @(negedge clk);
      end
      if (m_busy) chk("run_timeout", 32'(m_busy), 32'd0);
      start = 0; abort = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, dn, mu, dc, ac;
      repeat (2) @(negedge clk);
      chk("rst_outs_1", 32'(outs_1), 32'd0);
      chk("rst_outs_4", 32'(outs_4), 32'd0);
      rst_n = 1;

      go(3'd2, 3'd5, 3'd3, 4'd1, 1'b0);
      run(-1, -1, n, dn, mu, dc, ac);
      chk("t1_len", n, 7);
      chk("t1_done_cnt", dn, 1);
      chk("t1_done_cyc", dc, 6);
      chk("t1_mult", mu, 1);
      chk("t1_st1", st_hist[1], 1);
      chk("t1_st2", st_hist[2], 2);
      chk("t1_st4", st_hist[4], 4);
      chk("t1_st5", st_hist[5], 5);
      chk("t1_q", sb.size(), 0);

      go(3'd6, 3'd0, 3'd7, 4'd3, 1'b0);
      run(-1, -1, n, dn, mu, dc, ac);
      chk("t2_len", n, 17);
      chk("t2_done_cnt", dn, 1);
      chk("t2_done_cyc", dc, 16);
      chk("t2_q", sb.size(), 0);

      go(3'd1, 3'd2, 3'd4, 4'd1, 1'b1);
      run(-1, -1, n, dn, mu, dc, ac);
      chk("t3_mult", mu, 4);
      chk("t3_mult_start", st_hist[3], 3);
      chk("t3_mult_end", st_hist[7], 4);
      chk("t3_done_cyc", dc, 9);
      chk("t3_len", n, 10);
      chk("t3_q", sb.size(), 0);

      go(3'd3, 3'd4, 3'd5, 4'd0, 1'b0);
      run(2, -1, n, dn, mu, dc, ac);
      chk("t4_len", n, 7);
      chk("t4_done_cnt", dn, 1);
      chk("t4_q", sb.size(), 0);

      go(3'd1, 3'd2, 3'd3, 4'd3, 1'b0);
      run(-1, 1, n, dn, mu, dc, ac);
      chk("t5_abort_cyc", ac, 8);
      chk("t5_idle_next", n, ac + 1);
      chk("t5_st_idle", st_hist[n], 0);
      chk("t5_no_done", dn, 0);
      chk("t5_q_left", sb.size(), 7);
      sb.delete();

      go(3'd0, 3'd1, 3'd2, 4'd2, 1'b0);
      for (int i = 0; i < 50 && m_st != 3'd4; i++) @(negedge clk);
      chk("t6_reach_write", 32'(m_st), 32'd4);
      #2 rst_n = 0;
      #1 chk("t6_async_outs", 32'(outs_1), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("t6_idle_after", 32'(outs_1), 32'd0);

      go(3'd4, 3'd4, 3'd4, 4'd2, 1'b0);
      run(-1, -1, n, dn, mu, dc, ac);
      chk("t7_len", n, 12);
      chk("t7_done_cnt", dn, 1);
      chk("t7_q", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
